// File: rtl/arp_resolver_pkg.sv
// Shared types and constants for the ARP resolver and its cache.
package arp_resolver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOOKUP     = 3'd1,
    ST_QUERY      = 3'd2,
    ST_WAIT_REPLY = 3'd3,
    ST_RESPOND    = 3'd4
  } state_t;

  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  typedef struct packed {
    logic        valid;
    logic [31:0] ip;
    logic [47:0] mac;
  } cache_entry_t;

endpackage

// File: rtl/arp_resolver_cache.sv
// Fully-associative IP->MAC cache: in-place overwrite, round-robin replacement,
// bulk clear, and same-cycle write forwarding onto the combinational lookup.
module arp_cache
  import arp_resolver_pkg::*;
#(
  parameter int unsigned ENTRIES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        wr_valid,
  input  logic [31:0] wr_ip,
  input  logic [47:0] wr_mac,
  input  logic [31:0] lookup_ip,
  output logic        hit,
  output logic [47:0] mac
);

  localparam int unsigned PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  cache_entry_t  entries [ENTRIES];
  logic [PW-1:0] ptr;
  logic [PW-1:0] wr_idx;
  logic          wr_match;
  logic          wr_en;

  assign wr_en = wr_valid && (wr_ip != '0);

  always_comb begin
    wr_match = 1'b0;
    wr_idx   = ptr;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!wr_match && entries[i].valid && entries[i].ip == wr_ip) begin
        wr_match = 1'b1;
        wr_idx   = PW'(i);
      end
    end
  end

  // A clear in this cycle hides both the stored entries and the forwarded write.
  always_comb begin
    hit = 1'b0;
    mac = '0;
    if (!clear) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        if (entries[i].valid && entries[i].ip == lookup_ip) begin
          hit = 1'b1;
          mac = entries[i].mac;
        end
      end
      if (wr_en && wr_ip == lookup_ip) begin
        hit = 1'b1;
        mac = wr_mac;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) entries[i] <= '0;
      ptr <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < ENTRIES; i++) entries[i].valid <= 1'b0;
      ptr <= '0;
    end else if (wr_en) begin
      entries[wr_idx] <= '{valid: 1'b1, ip: wr_ip, mac: wr_mac};
      if (!wr_match) ptr <= (ptr == PW'(ENTRIES - 1)) ? '0 : ptr + PW'(1);
    end
  end

endmodule

// File: rtl/arp_resolver.sv
// Next-hop MAC resolver: request/response FSM, subnet/gateway target selection,
// query retry with timeout, backed by a learned IP->MAC cache.
module arp_resolver
  import arp_resolver_pkg::*;
#(
  parameter int unsigned CACHE_ENTRIES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 125000,
  parameter int unsigned RETRY_COUNT    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arp_request_valid,
  output logic        arp_request_ready,
  input  logic [31:0] arp_request_ip,
  output logic        arp_response_valid,
  input  logic        arp_response_ready,
  output logic        arp_response_error,
  output logic [47:0] arp_response_mac,
  output logic        m_query_valid,
  input  logic        m_query_ready,
  output logic [31:0] m_query_ip,
  input  logic        cache_write_valid,
  input  logic [31:0] cache_write_ip,
  input  logic [47:0] cache_write_mac,
  input  logic        clear_cache,
  input  logic [31:0] local_ip,
  input  logic [31:0] gateway_ip,
  input  logic [31:0] subnet_mask
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned RW = (RETRY_COUNT > 0) ? $clog2(RETRY_COUNT + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LOAD = RW'(RETRY_COUNT);

  state_t        state, state_next;
  logic [31:0]   dest_ip, dest_ip_next;
  logic [TW-1:0] timer, timer_next;
  logic [RW-1:0] retries, retries_next;
  logic          req_ready_next, resp_valid_next, resp_error_next, query_valid_next;
  logic [47:0]   resp_mac_next;
  logic [31:0]   query_ip_next;

  logic          on_subnet, broadcast, gw_error;
  logic [31:0]   target;
  logic          cache_hit;
  logic [47:0]   cache_mac;

  assign on_subnet = (dest_ip & subnet_mask) == (local_ip & subnet_mask);
  assign target    = on_subnet ? dest_ip : gateway_ip;
  assign gw_error  = !on_subnet && (gateway_ip == '0);
  assign broadcast = (dest_ip == '1) || ((dest_ip & ~subnet_mask) == ~subnet_mask);

  arp_cache #(
    .ENTRIES(CACHE_ENTRIES)
  ) u_cache (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear_cache),
    .wr_valid  (cache_write_valid),
    .wr_ip     (cache_write_ip),
    .wr_mac    (cache_write_mac),
    .lookup_ip (target),
    .hit       (cache_hit),
    .mac       (cache_mac)
  );

  always_comb begin
    state_next       = state;
    dest_ip_next     = dest_ip;
    timer_next       = timer;
    retries_next     = retries;
    req_ready_next   = 1'b0;
    resp_valid_next  = arp_response_valid;
    resp_error_next  = arp_response_error;
    resp_mac_next    = arp_response_mac;
    query_valid_next = 1'b0;
    query_ip_next    = m_query_ip;
    case (state)
      ST_IDLE: begin
        if (arp_request_valid && arp_request_ready) begin
          dest_ip_next = arp_request_ip;
          state_next   = ST_LOOKUP;
        end else begin
          req_ready_next = 1'b1;
        end
      end
      ST_LOOKUP: begin
        state_next      = ST_RESPOND;
        resp_valid_next = 1'b1;
        resp_error_next = 1'b0;
        if (broadcast) begin
          resp_mac_next = BCAST_MAC;
        end else if (gw_error) begin
          resp_error_next = 1'b1;
          resp_mac_next   = '0;
        end else if (cache_hit) begin
          resp_mac_next = cache_mac;
        end else begin
          state_next       = ST_QUERY;
          resp_valid_next  = 1'b0;
          retries_next     = RETRY_LOAD;
          query_valid_next = 1'b1;
          query_ip_next    = target;
        end
      end
      ST_QUERY: begin
        query_valid_next = 1'b1;
        if (m_query_valid && m_query_ready) begin
          query_valid_next = 1'b0;
          retries_next     = retries - RW'(1);
          timer_next       = '0;
          state_next       = ST_WAIT_REPLY;
        end
      end
      ST_WAIT_REPLY: begin
        timer_next = timer + TW'(1);
        if (cache_write_valid && cache_write_ip == target) begin
          state_next      = ST_RESPOND;
          resp_valid_next = 1'b1;
          resp_error_next = 1'b0;
          resp_mac_next   = cache_write_mac;
        end else if (timer == TIMER_LAST) begin
          if (retries != '0) begin
            state_next       = ST_QUERY;
            query_valid_next = 1'b1;
          end else begin
            state_next      = ST_RESPOND;
            resp_valid_next = 1'b1;
            resp_error_next = 1'b1;
            resp_mac_next   = '0;
          end
        end
      end
      ST_RESPOND: begin
        if (arp_response_ready) begin
          resp_valid_next = 1'b0;
          req_ready_next  = 1'b1;
          state_next      = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      dest_ip            <= '0;
      timer              <= '0;
      retries            <= '0;
      arp_request_ready  <= 1'b0;
      arp_response_valid <= 1'b0;
      arp_response_error <= 1'b0;
      arp_response_mac   <= '0;
      m_query_valid      <= 1'b0;
      m_query_ip         <= '0;
    end else begin
      state              <= state_next;
      dest_ip            <= dest_ip_next;
      timer              <= timer_next;
      retries            <= retries_next;
      arp_request_ready  <= req_ready_next;
      arp_response_valid <= resp_valid_next;
      arp_response_error <= resp_error_next;
      arp_response_mac   <= resp_mac_next;
      m_query_valid      <= query_valid_next;
      m_query_ip         <= query_ip_next;
    end
  end

endmodule

// File: tb/tb_arp_resolver.sv
// Directed bench for arp_resolver: table of immediate-response vectors plus
// hand sequences for miss/learn, forwarding, clear, retry timeout, eviction and reset.
module tb_arp_resolver;

  localparam int unsigned TMO = 16;
  localparam int unsigned RETRIES = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arp_request_valid, arp_request_ready;
  logic [31:0] arp_request_ip;
  logic        arp_response_valid, arp_response_ready, arp_response_error;
  logic [47:0] arp_response_mac;
  logic        m_query_valid, m_query_ready;
  logic [31:0] m_query_ip;
  logic        cache_write_valid;
  logic [31:0] cache_write_ip;
  logic [47:0] cache_write_mac;
  logic        clear_cache;
  logic [31:0] local_ip, gateway_ip, subnet_mask;

  int checks = 0;
  int errors = 0;

  arp_resolver #(
    .CACHE_ENTRIES (8),
    .TIMEOUT_CYCLES(TMO),
    .RETRY_COUNT   (RETRIES)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .arp_request_valid (arp_request_valid),
    .arp_request_ready (arp_request_ready),
    .arp_request_ip    (arp_request_ip),
    .arp_response_valid(arp_response_valid),
    .arp_response_ready(arp_response_ready),
    .arp_response_error(arp_response_error),
    .arp_response_mac  (arp_response_mac),
    .m_query_valid     (m_query_valid),
    .m_query_ready     (m_query_ready),
    .m_query_ip        (m_query_ip),
    .cache_write_valid (cache_write_valid),
    .cache_write_ip    (cache_write_ip),
    .cache_write_mac   (cache_write_mac),
    .clear_cache       (clear_cache),
    .local_ip          (local_ip),
    .gateway_ip        (gateway_ip),
    .subnet_mask       (subnet_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] gw;
    logic [31:0] ip;
    logic        err;
    logic [47:0] mac;
  } vec_t;

  localparam logic [31:0] GW  = 32'hC0A8_0101;
  localparam logic [47:0] BC  = 48'hFFFF_FFFF_FFFF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] ip, input logic [47:0] mac);
    cache_write_valid = 1'b1;
    cache_write_ip    = ip;
    cache_write_mac   = mac;
    tick();
    cache_write_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_cache = 1'b1;
    tick();
    clear_cache = 1'b0;
  endtask

  // Returns during the LOOKUP cycle (cycle N+1).
  task automatic accept(input logic [31:0] ip);
    int n = 0;
    while (!arp_request_ready && n < 64) begin
      tick();
      n++;
    end
    check("accept_ready", 64'(arp_request_ready), 64'd1);
    arp_request_valid = 1'b1;
    arp_request_ip    = ip;
    tick();
    arp_request_valid = 1'b0;
  endtask

  task automatic await_out(output int lat);
    lat = 1;
    while (!arp_response_valid && !m_query_valid && lat < 64) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume(input string name);
    arp_response_ready = 1'b1;
    tick();
    arp_response_ready = 1'b0;
    check({name, "_ready_after"}, 64'(arp_request_ready), 64'd1);
    check({name, "_valid_drop"}, 64'(arp_response_valid), 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    gateway_ip = v.gw;
    accept(v.ip);
    check({v.name, "_busy"}, 64'(arp_request_ready), 64'd0);
    await_out(lat);
    check({v.name, "_latency"}, 64'(lat), 64'd2);
    check({v.name, "_noquery"}, 64'(m_query_valid), 64'd0);
    check({v.name, "_err"}, 64'(arp_response_error), 64'(v.err));
    check({v.name, "_mac"}, 64'(arp_response_mac), 64'(v.mac));
    consume(v.name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   lat;
    int   qcyc[4];
    int   qcnt;
    int   cyc;
    int   rcyc;

    vecs[0] = '{"hit_local",    GW,    32'hC0A8_0114, 1'b0, 48'h0200_0000_0020};
    vecs[1] = '{"bcast_subnet", GW,    32'hC0A8_01FF, 1'b0, BC};
    vecs[2] = '{"bcast_all",    GW,    32'hFFFF_FFFF, 1'b0, BC};
    vecs[3] = '{"via_gw",       GW,    32'h0808_0808, 1'b0, 48'h0200_0000_0001};
    vecs[4] = '{"via_gw2",      GW,    32'h0A00_0001, 1'b0, 48'h0200_0000_0001};
    vecs[5] = '{"no_gw",        32'h0, 32'h0808_0808, 1'b1, 48'h0};
    vecs[6] = '{"local_no_gw",  32'h0, 32'hC0A8_0114, 1'b0, 48'h0200_0000_0020};
    vecs[7] = '{"bcast_no_gw",  32'h0, 32'hFFFF_FFFF, 1'b0, BC};

    rst_n = 1'b0;
    arp_request_valid = 1'b0; arp_request_ip = '0;
    arp_response_ready = 1'b0; m_query_ready = 1'b0;
    cache_write_valid = 1'b0; cache_write_ip = '0; cache_write_mac = '0;
    clear_cache = 1'b0;
    local_ip = 32'hC0A8_010A; gateway_ip = GW; subnet_mask = 32'hFFFF_FF00;

    // Reset values
    repeat (3) tick();
    check("rst_ready", 64'(arp_request_ready), 64'd0);
    check("rst_resp_valid", 64'(arp_response_valid), 64'd0);
    check("rst_resp_err", 64'(arp_response_error), 64'd0);
    check("rst_resp_mac", 64'(arp_response_mac), 64'd0);
    check("rst_qvalid", 64'(m_query_valid), 64'd0);
    check("rst_qip", 64'(m_query_ip), 64'd0);
    rst_n = 1'b1;
    check("ready_before_edge", 64'(arp_request_ready), 64'd0);
    tick();
    check("ready_first_edge", 64'(arp_request_ready), 64'd1);

    wr(32'hC0A8_0114, 48'h0200_0000_0020);

    // Off-subnet miss: query the gateway, learn it from a receiver write
    accept(32'h0808_0808);
    await_out(lat);
    check("gwmiss_latency", 64'(lat), 64'd2);
    check("gwmiss_qvalid", 64'(m_query_valid), 64'd1);
    check("gwmiss_qip", 64'(m_query_ip), 64'(GW));
    check("gwmiss_noresp", 64'(arp_response_valid), 64'd0);
    m_query_ready = 1'b1;
    tick();
    m_query_ready = 1'b0;
    check("gwmiss_qdrop", 64'(m_query_valid), 64'd0);
    tick();
    tick();
    check("gwmiss_waiting", 64'(arp_response_valid), 64'd0);
    wr(GW, 48'h0200_0000_0001);
    check("learn_valid", 64'(arp_response_valid), 64'd1);
    check("learn_mac", 64'(arp_response_mac), 64'h0200_0000_0001);
    check("learn_err", 64'(arp_response_error), 64'd0);
    consume("learn");

    foreach (vecs[i]) run_vec(vecs[i]);
    gateway_ip = GW;

    // Write forwarded into the LOOKUP cycle
    accept(32'hC0A8_011E);
    cache_write_valid = 1'b1; cache_write_ip = 32'hC0A8_011E; cache_write_mac = 48'h0200_0000_0030;
    tick();
    cache_write_valid = 1'b0;
    check("fwd_valid", 64'(arp_response_valid), 64'd1);
    check("fwd_noquery", 64'(m_query_valid), 64'd0);
    check("fwd_mac", 64'(arp_response_mac), 64'h0200_0000_0030);
    consume("fwd");

    // Clear in the LOOKUP cycle beats both the stored entry and a same-cycle write
    accept(32'hC0A8_0114);
    clear_cache = 1'b1;
    cache_write_valid = 1'b1; cache_write_ip = 32'hC0A8_0114; cache_write_mac = 48'h0200_0000_00AA;
    tick();
    clear_cache = 1'b0;
    cache_write_valid = 1'b0;
    check("clr_qvalid", 64'(m_query_valid), 64'd1);
    check("clr_noresp", 64'(arp_response_valid), 64'd0);
    check("clr_qip", 64'(m_query_ip), 64'hC0A8_0114);
    m_query_ready = 1'b1;
    tick();
    m_query_ready = 1'b0;
    wr(32'hC0A8_0114, 48'h0200_0000_0021);
    check("clr_reply_valid", 64'(arp_response_valid), 64'd1);
    check("clr_reply_mac", 64'(arp_response_mac), 64'h0200_0000_0021);
    consume("clr_reply");

    // No reply: three queries, then error with MAC 0
    pulse_clear();
    accept(32'h0808_0808);
    m_query_ready = 1'b1;
    qcnt = 0;
    cyc  = 0;
    rcyc = -1;
    while (cyc < 200) begin
      if (arp_response_valid) begin
        rcyc = cyc;
        break;
      end
      if (m_query_valid) begin
        if (qcnt < 4) qcyc[qcnt] = cyc;
        qcnt++;
        check("tmo_qip", 64'(m_query_ip), 64'(GW));
      end
      tick();
      cyc++;
    end
    m_query_ready = 1'b0;
    // Accept edge to retry decision is TMO edges; the re-issued query shows a cycle later.
    check("tmo_query_count", 64'(qcnt), 64'd3);
    check("tmo_gap1", 64'(qcyc[1] - qcyc[0]), 64'(TMO + 1));
    check("tmo_gap2", 64'(qcyc[2] - qcyc[1]), 64'(TMO + 1));
    check("tmo_gap_err", 64'(rcyc - qcyc[2]), 64'(TMO + 1));
    check("tmo_err", 64'(arp_response_error), 64'd1);
    check("tmo_mac", 64'(arp_response_mac), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", 64'(arp_response_valid), 64'd1);
      check("hold_err", 64'(arp_response_error), 64'd1);
    end
    consume("tmo");

    // Round-robin eviction and in-place overwrite
    pulse_clear();
    for (int i = 0; i < 9; i++) wr(32'hC0A8_0165 + 32'(i), 48'h0200_0000_0100 + 48'(i));
    run_vec('{"evict_keep2", GW, 32'hC0A8_0166, 1'b0, 48'h0200_0000_0101});
    run_vec('{"evict_new9",  GW, 32'hC0A8_016D, 1'b0, 48'h0200_0000_0108});
    wr(32'hC0A8_0167, 48'h0200_0000_00BB);
    run_vec('{"rewrite",     GW, 32'hC0A8_0167, 1'b0, 48'h0200_0000_00BB});
    run_vec('{"rewrite_keep2", GW, 32'hC0A8_0166, 1'b0, 48'h0200_0000_0101});
    run_vec('{"rewrite_keep4", GW, 32'hC0A8_0168, 1'b0, 48'h0200_0000_0103});
    accept(32'hC0A8_0165);
    await_out(lat);
    check("evicted_miss", 64'(m_query_valid), 64'd1);
    check("evicted_qip", 64'(m_query_ip), 64'hC0A8_0165);
    m_query_ready = 1'b1;
    tick();
    m_query_ready = 1'b0;
    tick();

    // Asynchronous reset while waiting for a reply
    rst_n = 1'b0;
    #1;
    check("mid_rst_qip", 64'(m_query_ip), 64'd0);
    check("mid_rst_qvalid", 64'(m_query_valid), 64'd0);
    check("mid_rst_resp", 64'(arp_response_valid), 64'd0);
    check("mid_rst_ready", 64'(arp_request_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    check("mid_rel_ready0", 64'(arp_request_ready), 64'd0);
    tick();
    check("mid_rel_ready1", 64'(arp_request_ready), 64'd1);

    // Reset wipes the cache: a previously cached entry now misses
    accept(32'hC0A8_0166);
    await_out(lat);
    check("post_rst_latency", 64'(lat), 64'd2);
    check("post_rst_miss", 64'(m_query_valid), 64'd1);
    check("post_rst_noresp", 64'(arp_response_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arp_resolver.md
# arp_resolver

Resolves the next-hop MAC address for each outgoing IPv4 packet. It serves the ARP request/response handshake issued by the IP transmit path and holds a small fully-associative IP→MAC cache. On a cache miss it issues query requests to the ARP frame transmitter, retrying on timeout. It learns mappings from the ARP frame receiver.

## Interface
- `CACHE_ENTRIES`, default 8: cache depth; power of two, 2..32.
- `TIMEOUT_CYCLES`, default 125000: cycles to wait for a reply after each query.
- `RETRY_COUNT`, default 3: total queries sent before the block reports an error.
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
  - `clk`  in  1  clock.
  - `rst_n`  in  1  asynchronous active-low reset.
- `arp_request_valid`  in  1  resolution request from the IP transmit path.
- `arp_request_ready`  out  1  request accepted when valid and ready are both high.
- `arp_request_ip`  in  32  destination IP to resolve.
- `arp_response_valid`  out  1  result available.
- `arp_response_ready`  in  1  result consumed when valid and ready are both high.
- `arp_response_error`  out  1  resolution failed; MAC output is 0.
- `arp_response_mac`  out  48  resolved next-hop MAC.
- `m_query_valid`  out  1  request to transmit an ARP who-has.
- `m_query_ready`  in  1  ARP transmitter accepted the query.
- `m_query_ip`  out  32  IP to query.
- `cache_write_valid`  in  1  learned mapping from the ARP receiver; single-cycle strobe, always accepted.
- `cache_write_ip`  in  32  learned IP.
- `cache_write_mac`  in  48  learned MAC.
- `clear_cache`  in  1  invalidate all cache entries.
- `local_ip`  in  32  configuration: this node's IP.
- `gateway_ip`  in  32  configuration: default gateway IP.
- `subnet_mask`  in  32  configuration: local subnet mask.

## Operation
- **Target selection**, computed from the captured request IP `D`:
  - If `(D & mask) == (local_ip & mask)`, the target is `D`.
  - Otherwise the target is `gateway_ip`.
  - If the target is off-subnet and `gateway_ip == 0`, the result is an error.
- **Broadcast:** if `D == 32'hFFFFFFFF` or `(D & ~mask) == ~mask`, the result is MAC `48'hFFFFFFFFFFFF` with no cache access.
- **States:**
  - IDLE: `arp_request_ready` = 1. On accept, capture `D`, go to LOOKUP.
  - LOOKUP (exactly 1 cycle):
    - Broadcast → RESPOND with the broadcast MAC.
    - Gateway error → RESPOND with error.
    - Cache hit → RESPOND with the cached MAC.
    - Miss → QUERY, with the retry counter loaded to `RETRY_COUNT`.
  - QUERY: hold `m_query_valid` = 1 and `m_query_ip` = target until ready. On ready, decrement the retry counter, clear the timer, go to WAIT_REPLY.
  - WAIT_REPLY:
    - A cache write whose IP equals the target → RESPOND with that MAC.
    - Timer reaches `TIMEOUT_CYCLES-1` with retries left → QUERY.
    - Timer reaches `TIMEOUT_CYCLES-1` with no retries left → RESPOND with error and MAC = 0.
  - RESPOND: hold `arp_response_valid` with stable error/MAC until ready, then go to IDLE.
- **Cache writes** (accepted in every state):
  - If the IP is already present, overwrite that entry in place.
  - Otherwise write the entry at the round-robin pointer and advance the pointer, wrapping at `CACHE_ENTRIES`.
  - Writes with IP 0 are ignored.
- **Write in the same cycle as LOOKUP:** a matching `cache_write_ip` is forwarded and counts as a hit, returning `cache_write_mac`.
- **`clear_cache`:** clears all valid bits and resets the pointer. It has priority over a same-cycle write, and a LOOKUP in that cycle sees a miss. An in-flight QUERY/WAIT_REPLY continues.
- **Configuration inputs** must be stable while not in IDLE.

## Timing
- **Reset values:**
  - State IDLE, all valid bits 0, counters 0.
  - `arp_request_ready` = 0 during reset, 1 from the first clock edge after `rst_n` rises.
  - `arp_response_valid`, `arp_response_error`, `m_query_valid` = 0.
  - `arp_response_mac` = 0, `m_query_ip` = 0.
- **Reset mid-operation:** asynchronous abort to the reset values; pending requests are lost.
- **Latency:**
  - Hit or broadcast: accept at cycle N, LOOKUP at N+1, `arp_response_valid` registered high at N+2.
  - Miss: `m_query_valid` high at N+2.
  - Learned reply at cycle M: response valid at M+1.
- **Outputs and handshakes:**
  - All outputs are registered.
  - `arp_request_ready` drops the cycle after accept; at most one request is outstanding.
  - After a response handshake at cycle R, ready is 1 at R+1.
- **Timeout:** exactly `TIMEOUT_CYCLES` cycles from query accept to the retry decision.

## Structure
- **Shared package:** the state enum, a broadcast MAC constant, and a `cache_entry_t` struct (valid, ip[31:0], mac[47:0]).
- **Sub-module `arp_cache`:** entry storage, parallel compare, in-place overwrite, round-robin pointer, clear, and write forwarding. It exposes a combinational lookup (`hit`, `mac`) for a given IP.
- **Top level:** the FSM, target selection, timer, and retry counter.

## Test plan
- Config local 192.168.1.10/255.255.255.0, gateway 192.168.1.1. Write 192.168.1.20 → 02:00:00:00:00:20, then request 192.168.1.20 → response at N+2, MAC 02:00:00:00:00:20, no query.
- Request 8.8.8.8 with the gateway not cached → `m_query_ip` = 192.168.1.1. Inject a write for 192.168.1.1 → 02:00:00:00:00:01 → response with that MAC one cycle later.
- Request 192.168.1.255 and 255.255.255.255 → FF:FF:FF:FF:FF:FF, no query.
- `TIMEOUT_CYCLES`=16, `RETRY_COUNT`=3, no reply → exactly 3 queries, 16 cycles apart, then error=1 and MAC=0. Hold `arp_response_ready` low 5 cycles and check valid stays high.
- Write 9 distinct IPs with 8 entries → the first is evicted (miss). Rewrite an existing IP with a new MAC → no eviction, new MAC returned. `clear_cache` → all miss.
- Assert `rst_n` low during WAIT_REPLY → outputs go to reset values immediately; ready is 1 one edge after release.
